// File: rtl/count12_pkg.sv
// Shared types and constants for the mod-12 counter monitor.
// Build option COUNT12_MON_STATS_EN enables the wrap/error statistics counters.
package count12_pkg;

  typedef enum logic [1:0] {
    ST_UNSYNC = 2'd0,
    ST_SYNC   = 2'd1,
    ST_FAULT  = 2'd2
  } state_t;

  localparam logic [3:0] CNT_MOD = 4'd12;
  localparam logic [3:0] CNT_MAX = 4'd11;

  // An out-of-range sample predicts 0 so the prediction never leaves 0..11.
  function automatic logic [3:0] predict(input logic [3:0] v, input logic en);
    logic [3:0] nxt;
    nxt = v;
    if (v >= CNT_MOD) begin
      nxt = 4'd0;
    end else if (en) begin
      nxt = (v == CNT_MAX) ? 4'd0 : v + 4'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/count12_sat_ctr.sv
// Saturating event counter: +1 per cycle with inc high, holds at all-ones.
// Count is visible the cycle after the increment request.
module count12_sat_ctr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/count12_monitor.sv
// Watches a mod-12 counter, predicts its next value and flags wraps, sequence and range errors.
// All outputs registered; wrap_cnt/err_cnt are live only with COUNT12_MON_STATS_EN defined.
module count12_monitor
  import count12_pkg::*;
#(
  parameter int WRAP_W = 16,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_count,
  input  logic [3:0]        cnt_in,
  input  logic              clr_err,
  output logic [1:0]        state,
  output logic              in_sync,
  output logic [3:0]        expected,
  output logic              wrap_tick,
  output logic              err_seq,
  output logic              err_range,
  output logic              fault,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic [ERR_W-1:0]  err_cnt
);

  state_t     state_q, state_d;
  logic [3:0] prev_q, prev_d;
  logic       vc_q, vc_d;
  logic [3:0] expected_q, expected_d;
  logic       wrap_q, wrap_d;
  logic       err_seq_q, err_seq_d;
  logic       err_range_q, err_range_d;
  logic       in_sync_q, in_sync_d;
  logic       fault_q, fault_d;
  logic       in_range;

  always_comb begin
    state_d     = state_q;
    wrap_d      = 1'b0;
    err_seq_d   = 1'b0;
    in_range    = (cnt_in < CNT_MOD);
    err_range_d = !in_range;
    prev_d      = cnt_in;
    vc_d        = valid_count;
    // expected_q always equals predict(prev_q, vc_q); computing it one cycle early keeps it a flop.
    expected_d  = predict(cnt_in, valid_count);

    case (state_q)
      ST_UNSYNC: begin
        if (in_range) state_d = ST_SYNC;
      end
      ST_SYNC: begin
        if (!in_range || (cnt_in != expected_q)) begin
          state_d   = ST_FAULT;
          err_seq_d = 1'b1;
        end else if (vc_q && (prev_q == CNT_MAX) && (cnt_in == 4'd0)) begin
          wrap_d = 1'b1;
        end
      end
      ST_FAULT: begin
        if (clr_err) state_d = ST_UNSYNC;
      end
      default: state_d = ST_UNSYNC;
    endcase

    in_sync_d = (state_d == ST_SYNC);
    fault_d   = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_UNSYNC;
      prev_q      <= 4'd0;
      vc_q        <= 1'b0;
      expected_q  <= 4'd0;
      wrap_q      <= 1'b0;
      err_seq_q   <= 1'b0;
      err_range_q <= 1'b0;
      in_sync_q   <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      vc_q        <= vc_d;
      expected_q  <= expected_d;
      wrap_q      <= wrap_d;
      err_seq_q   <= err_seq_d;
      err_range_q <= err_range_d;
      in_sync_q   <= in_sync_d;
      fault_q     <= fault_d;
    end
  end

  assign state     = state_q;
  assign in_sync   = in_sync_q;
  assign expected  = expected_q;
  assign wrap_tick = wrap_q;
  assign err_seq   = err_seq_q;
  assign err_range = err_range_q;
  assign fault     = fault_q;

`ifdef COUNT12_MON_STATS_EN
  // A cycle with both err_seq and err_range is a single error event.
  count12_sat_ctr #(.W(WRAP_W)) u_wrap_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (wrap_d),
    .cnt   (wrap_cnt)
  );

  count12_sat_ctr #(.W(ERR_W)) u_err_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (err_seq_d | err_range_d),
    .cnt   (err_cnt)
  );
`else
  assign wrap_cnt = '0;
  assign err_cnt  = '0;
`endif

endmodule

// File: doc/count12_monitor.md
COUNT12_MONITOR -- requirements
Module: count12_monitor

Interface
REQ-001 Parameter WRAP_W, default 16, width of the saturating wrap counter.
REQ-002 Parameter ERR_W, default 8, width of the saturating error counter.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 valid_count  input  1  the enable driven to the mod-12 counter under observation.
REQ-006 cnt_in  input  4  the observed counter value.
REQ-007 clr_err  input  1  single-cycle request to leave FAULT and resynchronise.
REQ-008 state  output  2  current FSM state: UNSYNC=0, SYNC=1, FAULT=2.
REQ-009 in_sync  output  1  high while state is SYNC.
REQ-010 expected  output  4  next cnt_in value the monitor predicts.
REQ-011 wrap_tick  output  1  one-cycle pulse on a checked 11->0 transition.
REQ-012 err_seq  output  1  one-cycle pulse on a sequence mismatch.
REQ-013 err_range  output  1  one-cycle pulse when cnt_in is greater than 11.
REQ-014 fault  output  1  high while state is FAULT.
REQ-015 wrap_cnt  output  WRAP_W  saturating count of wrap_tick pulses.
REQ-016 err_cnt  output  ERR_W  saturating count of err_seq and err_range events.

Function
REQ-017 Each cycle the block registers prev <= cnt_in and vc_d <= valid_count.
REQ-018 Prediction: if vc_d is 1, expected = 0 when prev is 11, else prev+1; if vc_d is 0, expected = prev.
REQ-019 UNSYNC: in-range cnt_in -> capture the value and go to SYNC next cycle; no sequence check is made.
REQ-020 UNSYNC, out-of-range cnt_in: stay in UNSYNC and pulse err_range.
REQ-021 SYNC, cnt_in equals expected: stay in SYNC.
REQ-022 SYNC, wrap: when prev is 11, vc_d is 1 and cnt_in is 0, wrap_tick pulses.
REQ-023 SYNC, mismatch: on any mismatch or out-of-range cnt_in, go to FAULT and pulse err_seq.
REQ-024 SYNC, out-of-range: err_range also pulses in the same cycle.
REQ-025 At most one err_seq pulse per FAULT entry.
REQ-026 FAULT: checking is suspended and no further err_seq pulses occur; err_range still pulses for out-of-range cnt_in.
REQ-027 FAULT with clr_err high -> UNSYNC next cycle.
REQ-028 clr_err is ignored in UNSYNC and SYNC.
REQ-029 All outputs are registered; each pulse is high for exactly the one cycle following the clk edge that sampled the offending or wrapping cnt_in.
REQ-030 expected is updated every cycle in all states.
REQ-031 A simultaneous error and wrap condition gives error priority; wrap_tick stays low.
REQ-032 Arithmetic is 4-bit unsigned; no value of 12 or more is ever produced on expected.

Reset
REQ-033 Asserting rst_n low, even mid-sequence, forces: state=UNSYNC, prev=0, vc_d=0, expected=0.
REQ-034 Also forced by reset: every pulse output low, fault=0, wrap_cnt=0, err_cnt=0.
REQ-035 After reset release, the first sampled in-range value becomes the sync point.

Configuration
REQ-036 Macro COUNT12_MON_STATS_EN defined: wrap_cnt and err_cnt are live.
REQ-037 Each counter increments by 1 per event and holds at its all-ones value.
REQ-038 Simultaneous err_seq and err_range count as one error event.
REQ-039 Macro absent: wrap_cnt and err_cnt are tied to 0 and no counter flops are built; all other behaviour is identical.

Structure
REQ-040 Shared package count12_pkg holds: the state enum, constant CNT_MOD=12, and constant CNT_MAX=11.
REQ-041 The saturating counter is sub-module count12_sat_ctr, parameterised by width and instantiated twice under the macro.

Verification
REQ-042 Reset, then valid_count=1 with the counter running 0..11,0..3 -> SYNC; one wrap_tick after 11->0; err_seq never pulses; wrap_cnt=1 (with stats).
REQ-043 In SYNC at cnt_in=5, hold valid_count=0 for 4 cycles with cnt_in=5 -> no error; expected=5 throughout.
REQ-044 In SYNC, force cnt_in 3->7 with vc_d=1 -> err_seq pulse, FAULT, fault=1; further mismatches give no new err_seq.
REQ-045 In FAULT, pulse clr_err, then drive cnt_in=9 -> UNSYNC, then SYNC; expected=10 when vc_d=1.
REQ-046 Drive cnt_in=13 in SYNC -> err_range and err_seq pulse in the same cycle; err_cnt increments by 1 only.
REQ-047 Assert rst_n mid-count at cnt_in=8 -> all outputs at reset values immediately; resync on the first in-range sample after release.
